// File: rtl/stopwatch_pkg.sv
// Shared types and BCD helpers for the stopwatch controller.
// Time words are packed BCD {m_tens, m_ones, s_tens, s_ones}.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0]  SEC_TENS_MAX  = 4'd5;
    localparam logic [15:0] TIME_ZERO     = 16'h0000;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Caller guarantees the input is below the terminal value, so minutes never wrap.
    function automatic logic [15:0] bcd_step_up(input logic [15:0] t);
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        {mt, mo, st, so} = t;
        if (so != BCD_DIGIT_MAX) begin
            so = so + 4'd1;
        end else begin
            so = 4'd0;
            if (st != SEC_TENS_MAX) begin
                st = st + 4'd1;
            end else begin
                st = 4'd0;
                if (mo != BCD_DIGIT_MAX) begin
                    mo = mo + 4'd1;
                end else begin
                    mo = 4'd0;
                    mt = mt + 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // Caller guarantees the input is non-zero.
    function automatic logic [15:0] bcd_step_down(input logic [15:0] t);
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = BCD_DIGIT_MAX;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = SEC_TENS_MAX;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = BCD_DIGIT_MAX;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    function automatic logic [15:0] bcd_clamp(input logic [15:0] t, input logic [7:0] max_mm);
        logic [7:0] mm;
        logic [3:0] st;
        logic [3:0] so;
        mm = {clamp_digit(t[15:12], BCD_DIGIT_MAX), clamp_digit(t[11:8], BCD_DIGIT_MAX)};
        st = clamp_digit(t[7:4], SEC_TENS_MAX);
        so = clamp_digit(t[3:0], BCD_DIGIT_MAX);
        // With valid BCD digits a plain binary compare orders minutes correctly.
        if (mm > max_mm) begin
            mm = max_mm;
        end
        return {mm, st, so};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, db_tick-paced debounce, press pulse.
// A press is only reported after the button has been seen released once since reset.
module btn_debounce #(
    parameter int DB_SAMPLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic db_tick,
    input  logic btn_raw,
    output logic press
);

    localparam logic [1:0] CNT_LAST = 2'(DB_SAMPLES - 1);

    logic [1:0] sync_q, sync_d;
    logic [1:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       armed_q, armed_d;
    logic       press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        cnt_d   = cnt_q;
        level_d = level_q;
        armed_d = armed_q;
        press_d = 1'b0;
        if (db_tick) begin
            if (!sync_q[1]) begin
                armed_d = 1'b1;
            end
            if (sync_q[1] != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_d = sync_q[1];
                    cnt_d   = 2'd0;
                    press_d = sync_q[1] & armed_q;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end else begin
                cnt_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= 2'd0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch / countdown mode controller sequencing a BCD mm:ss count on sec_tick.
// Event priority within a cycle: clear > load > start > sec_tick.
module stopwatch_ctrl #(
    parameter int         DB_SAMPLES = 2,
    parameter logic [7:0] MAX_MM     = 8'h59
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sec_tick,
    input  logic        db_tick,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_load,
    input  logic        mode_down,
    input  logic [15:0] load_val,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        done,
    output logic        done_pulse
);

    import stopwatch_pkg::*;

    localparam logic [15:0] TIME_TERM = {MAX_MM, 8'h59};

    logic start_evt, clear_evt, load_evt;

    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_start (
        .clk(clk), .rst_n(rst_n), .db_tick(db_tick), .btn_raw(btn_start), .press(start_evt)
    );
    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_clear (
        .clk(clk), .rst_n(rst_n), .db_tick(db_tick), .btn_raw(btn_clear), .press(clear_evt)
    );
    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_load (
        .clk(clk), .rst_n(rst_n), .db_tick(db_tick), .btn_raw(btn_load), .press(load_evt)
    );

    logic [1:0]  mode_sync_q, mode_sync_d;
    sw_state_e   state_q, state_d;
    logic [15:0] time_q, time_d;
    logic        done_pulse_q, done_pulse_d;
    logic [15:0] step_up_val, step_dn_val;
    logic        count_down;

    assign mode_sync_d = {mode_sync_q[0], mode_down};
    assign count_down  = mode_sync_q[1];
    assign step_up_val = bcd_step_up(time_q);
    assign step_dn_val = bcd_step_down(time_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_sync_q  <= 2'b00;
            state_q      <= ST_IDLE;
            time_q       <= TIME_ZERO;
            done_pulse_q <= 1'b0;
        end else begin
            mode_sync_q  <= mode_sync_d;
            state_q      <= state_d;
            time_q       <= time_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        if (clear_evt) begin
            state_d = ST_IDLE;
            time_d  = TIME_ZERO;
        end else if (load_evt && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
            time_d = bcd_clamp(load_val, MAX_MM);
        end else if (start_evt) begin
            // A tick coinciding with start is dropped on purpose.
            unique case (state_q)
                ST_IDLE:  state_d = (count_down && time_q == TIME_ZERO) ? ST_DONE : ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = state_q;
            endcase
        end else if (sec_tick && state_q == ST_RUN) begin
            if (!count_down) begin
                if (time_q == TIME_TERM) begin
                    state_d = ST_DONE;
                end else begin
                    time_d = step_up_val;
                    if (step_up_val == TIME_TERM) begin
                        state_d = ST_DONE;
                    end
                end
            end else begin
                if (time_q == TIME_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    time_d = step_dn_val;
                    if (step_dn_val == TIME_ZERO) begin
                        state_d = ST_DONE;
                    end
                end
            end
        end
    end

    always_comb begin
        done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        running      = (state_q == ST_RUN);
        done         = (state_q == ST_DONE);
        time_bcd     = time_q;
        done_pulse   = done_pulse_q;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl; db_tick and sec_tick are driven directly at compressed rates.
module tb_stopwatch_ctrl;

    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sec_tick;
    logic        db_tick;
    logic        btn_start;
    logic        btn_clear;
    logic        btn_load;
    logic        mode_down;
    logic [15:0] load_val;
    logic [15:0] time_bcd;
    logic        running;
    logic        done;
    logic        done_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int dp       = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DB_SAMPLES(DB), .MAX_MM(8'h59)) dut (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .db_tick(db_tick),
        .btn_start(btn_start), .btn_clear(btn_clear), .btn_load(btn_load),
        .mode_down(mode_down), .load_val(load_val), .time_bcd(time_bcd),
        .running(running), .done(done), .done_pulse(done_pulse)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // db_tick high for one cycle; optional sec_tick in the following cycle,
    // which is the cycle the resulting press event is seen by the FSM.
    task automatic db_pulse(input bit with_sec);
        @(negedge clk) db_tick = 1'b1;
        @(negedge clk) begin
            db_tick  = 1'b0;
            sec_tick = with_sec;
        end
        @(negedge clk) sec_tick = 1'b0;
    endtask

    task automatic press(input bit s, input bit c, input bit l, input bit with_sec);
        btn_start = s;
        btn_clear = c;
        btn_load  = l;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DB - 1; i++) db_pulse(1'b0);
        db_pulse(with_sec);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_load  = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DB; i++) db_pulse(1'b0);
    endtask

    task automatic sec_run(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk) sec_tick = 1'b1;
            @(negedge clk) begin
                sec_tick = 1'b0;
                if (done_pulse) pulses++;
            end
        end
    endtask

    initial begin
        int   rises;
        int   rise_cycle;
        logic prev_run;

        // Reset with start and load held high
        rst_n     = 1'b0;
        sec_tick  = 1'b0;
        db_tick   = 1'b0;
        btn_start = 1'b1;
        btn_clear = 1'b0;
        btn_load  = 1'b1;
        mode_down = 1'b0;
        load_val  = 16'h1234;
        repeat (3) @(negedge clk);
        check("reset_time", time_bcd, 16'h0000);
        check("reset_running", 16'(running), 16'h0);
        check("reset_done", 16'(done), 16'h0);
        check("reset_done_pulse", 16'(done_pulse), 16'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        repeat (3) db_pulse(1'b0);
        check("held_no_start", 16'(running), 16'h0);
        check("held_no_load", time_bcd, 16'h0000);
        btn_start = 1'b0;
        btn_load  = 1'b0;
        load_val  = 16'h0000;
        repeat (3) @(negedge clk);
        repeat (DB) db_pulse(1'b0);
        check("release_no_press", 16'(running), 16'h0);
        press(1, 0, 0, 0);
        check("rearm_start", 16'(running), 16'h1);
        press(0, 1, 0, 0);
        check("clear_idle", 16'(running), 16'h0);

        // Bouncing start: 5-cycle bounce for 40 cycles, db_tick every 25 cycles
        rises      = 0;
        rise_cycle = -1;
        prev_run   = running;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (running && !prev_run) begin
                rises++;
                rise_cycle = c;
            end
            prev_run  = running;
            btn_start = (c < 40) ? (((c / 5) % 2) == 0) : 1'b1;
            db_tick   = ((c % 25) == 24);
        end
        db_tick = 1'b0;
        check("bounce_one_press", 16'(rises), 16'd1);
        check("bounce_running", 16'(running), 16'h1);
        check("bounce_latency", 16'(rise_cycle >= 0 && rise_cycle <= 95), 16'h1);
        btn_start = 1'b0;
        repeat (3) @(negedge clk);
        repeat (DB) db_pulse(1'b0);
        check("release_keeps_run", 16'(running), 16'h1);
        press(0, 1, 0, 0);

        // Count up
        press(1, 0, 0, 0);
        sec_run(61, dp);
        check("up_61_time", time_bcd, 16'h0101);
        check("up_61_running", 16'(running), 16'h1);
        press(0, 1, 0, 0);
        load_val = 16'h5858;
        press(0, 0, 1, 0);
        check("load_5858", time_bcd, 16'h5858);
        press(1, 0, 0, 0);
        sec_run(61, dp);
        check("up_term_time", time_bcd, 16'h5959);
        check("up_term_done", 16'(done), 16'h1);
        check("up_term_running", 16'(running), 16'h0);
        check("up_term_pulses", 16'(dp), 16'd1);
        sec_run(3, dp);
        check("done_hold_time", time_bcd, 16'h5959);
        check("done_hold_pulses", 16'(dp), 16'd0);
        press(1, 0, 0, 0);
        check("start_in_done", 16'(done), 16'h1);
        load_val = 16'h0102;
        press(0, 0, 1, 0);
        check("load_in_done", time_bcd, 16'h5959);
        press(0, 1, 0, 0);
        check("clear_from_done", 16'(done), 16'h0);
        check("clear_time", time_bcd, 16'h0000);

        // Count down
        mode_down = 1'b1;
        repeat (4) @(negedge clk);
        load_val = 16'h0100;
        press(0, 0, 1, 0);
        check("load_0100", time_bcd, 16'h0100);
        press(1, 0, 0, 0);
        sec_run(59, dp);
        check("down_59_time", time_bcd, 16'h0001);
        check("down_59_running", 16'(running), 16'h1);
        sec_run(1, dp);
        check("down_zero_time", time_bcd, 16'h0000);
        check("down_zero_done", 16'(done), 16'h1);
        check("down_zero_pulse", 16'(dp), 16'd1);
        press(0, 1, 0, 0);
        load_val = 16'h0000;
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        check("down_from_zero_done", 16'(done), 16'h1);
        check("down_from_zero_time", time_bcd, 16'h0000);
        press(0, 1, 0, 0);

        // Priority
        mode_down = 1'b0;
        repeat (4) @(negedge clk);
        press(1, 0, 0, 0);
        sec_run(5, dp);
        check("up_5_time", time_bcd, 16'h0005);
        press(1, 1, 0, 1);
        check("clr_start_tick_time", time_bcd, 16'h0000);
        check("clr_start_tick_run", 16'(running), 16'h0);
        press(1, 0, 0, 0);
        sec_run(3, dp);
        press(1, 0, 0, 1);
        check("pause_tick_time", time_bcd, 16'h0003);
        check("pause_running", 16'(running), 16'h0);
        check("pause_done", 16'(done), 16'h0);
        press(1, 0, 0, 0);
        check("resume_running", 16'(running), 16'h1);
        load_val = 16'h1234;
        press(0, 0, 1, 0);
        check("load_in_run_time", time_bcd, 16'h0003);
        check("load_in_run_running", 16'(running), 16'h1);
        press(0, 1, 0, 0);

        // Clamp and count-up starting at the terminal value
        load_val = 16'h7A6F;
        press(0, 0, 1, 0);
        check("clamp_7a6f", time_bcd, 16'h5959);
        press(1, 0, 0, 0);
        check("start_at_term_running", 16'(running), 16'h1);
        sec_run(1, dp);
        check("term_first_tick_done", 16'(done), 16'h1);
        check("term_first_tick_time", time_bcd, 16'h5959);
        check("term_first_tick_pulse", 16'(dp), 16'd1);
        press(0, 1, 0, 0);
        check("final_clear_done", 16'(done), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
